// File: rtl/sdram_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// sdram_cmd_sequencer
//
// Main control state machine of the SDRAM memory controller. After reset it
// runs the SDRAM power-up sequence (precharge-all, two auto-refreshes, load
// mode). It then decodes the bus-request status from the bus-interface and
// bank-tracking logic into SDRAM commands: activate, read, write and
// precharge. Refresh is an interrupt handshake with the CPU: the refresh
// timer raises autoRef, the sequencer parks in ackWait with sdramIRQ high,
// and once the CPU acknowledges it precharges all banks and auto-refreshes.
//
// Ports
//   clk         in   clock, all state changes on the rising edge
//   rst         in   asynchronous, active-high reset
//   active      in   bus request pending
//   bankActive  in   target bank has an open row
//   newRow      in   request targets a different row than the open one
//   we_i        in   request is a write
//   autoRef     in   refresh timer expired, refresh required
//   initCount   in   power-up delay elapsed
//   irqAck      in   CPU acknowledges the refresh interrupt
//   command     out  SDRAM command {cs_n, ras_n, cas_n, we_n}
//   apc         out  auto-precharge, always 0
//   all_one     out  drive A10 high (precharge all banks)
//   sdramIRQ    out  refresh interrupt request to the CPU
//
// Configuration macro
//   SDRAM_REFRESH_IRQ_EN  defined: full CPU refresh handshake (sdramIRQ is
//                         driven, ackWait waits for irqAck).
//                         undefined (default): sdramIRQ tied 0 and irqAck is
//                         treated as always asserted, so ackWait lasts one
//                         cycle.
// ---------------------------------------------------------------------------
module sdram_cmd_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       active,
   input  logic       bankActive,
   input  logic       newRow,
   input  logic       we_i,
   input  logic       autoRef,
   input  logic       initCount,
   input  logic       irqAck,
   output logic [3:0] command,
   output logic       apc,
   output logic       all_one,
   output logic       sdramIRQ
);

   // SDRAM command encodings {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
   localparam logic [3:0] CMD_NOP       = 4'b0111;
   localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
   localparam logic [3:0] CMD_READ      = 4'b0101;
   localparam logic [3:0] CMD_WRITE     = 4'b0100;
   localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
   localparam logic [3:0] CMD_AUTO_REF  = 4'b0001;
   localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

   typedef enum logic [4:0] {
      ST_INIT0,
      ST_INIT1,
      ST_INIT2,
      ST_INIT3,
      ST_INIT4,
      ST_INIT5,
      ST_INIT6,
      ST_WAIT,
      ST_WRITE,
      ST_NOP5,
      ST_PRECH,
      ST_ACTIVE1,
      ST_ACTIVE2,
      ST_READ,
      ST_NOP0,
      ST_NOP1,
      ST_ACK_WAIT,
      ST_PRECH2,
      ST_NOP3
   } state_t;

   state_t     state;
   state_t     next_state;
   logic [3:0] cmd_q;
   logic       all_one_q;
   logic       irq_q;
   logic       ack_eff;
   logic       mealy_prech;
   logic [4:0] req_vec;

   // With the handshake disabled the acknowledge is forced true, so ackWait
   // falls straight through to the precharge-all. irqAck is then only kept
   // on an unused net so the port stays connected without lint noise.
`ifdef SDRAM_REFRESH_IRQ_EN
   localparam logic IRQ_EN = 1'b1;
   assign ack_eff = irqAck;
`else
   localparam logic IRQ_EN = 1'b0;
   logic unused_irq_ack;
   assign unused_irq_ack = irqAck;
   assign ack_eff        = 1'b1;
`endif

   assign req_vec = {autoRef, active, bankActive, newRow, we_i};

   // Request decode shared by waitState and write. Items are checked in
   // order, so autoRef=1 only reaches ackWait after every idle/request
   // pattern with autoRef=0 has been ruled out.
   function automatic state_t decode_req(input logic [4:0] v);
      state_t ns;
      casez (v)
         5'b01101: ns = ST_NOP5;     // write to the open row
         5'b01100: ns = ST_READ;     // read from the open row
         5'b0111?: ns = ST_PRECH;    // row miss, close the old row first
         5'b010?1: ns = ST_WRITE;    // bank idle, write
         5'b010?0: ns = ST_ACTIVE2;  // bank idle, open row then read
         5'b00???: ns = ST_WAIT;     // nothing to do
         default:  ns = ST_ACK_WAIT; // refresh wins over any request
      endcase
      return ns;
   endfunction

   // Moore command belonging to each state. ackWait shows NOP here; the
   // acknowledged precharge-all is overlaid combinationally below.
   function automatic logic [3:0] state_cmd(input state_t s);
      logic [3:0] c;
      case (s)
         ST_INIT0:    c = CMD_INHIBIT;
         ST_INIT1:    c = CMD_PRECHARGE;
         ST_INIT2:    c = CMD_AUTO_REF;
         ST_INIT3:    c = CMD_NOP;
         ST_INIT4:    c = CMD_AUTO_REF;
         ST_INIT5:    c = CMD_NOP;
         ST_INIT6:    c = CMD_LOAD_MODE;
         ST_WAIT:     c = CMD_NOP;
         ST_WRITE:    c = CMD_WRITE;
         ST_NOP5:     c = CMD_NOP;
         ST_PRECH:    c = CMD_PRECHARGE;
         ST_ACTIVE1:  c = CMD_ACTIVE;
         ST_ACTIVE2:  c = CMD_ACTIVE;
         ST_READ:     c = CMD_READ;
         ST_NOP0:     c = CMD_NOP;
         ST_NOP1:     c = CMD_NOP;
         ST_ACK_WAIT: c = CMD_NOP;
         ST_PRECH2:   c = CMD_AUTO_REF;
         ST_NOP3:     c = CMD_NOP;
         default:     c = CMD_NOP;
      endcase
      return c;
   endfunction

   // Next-state logic. Any encoding outside the enum recovers to waitState.
   always_comb begin
      next_state = state;
      case (state)
         ST_INIT0:    next_state = initCount ? ST_INIT1 : ST_INIT0;
         ST_INIT1:    next_state = ST_INIT2;
         ST_INIT2:    next_state = ST_INIT3;
         ST_INIT3:    next_state = ST_INIT4;
         ST_INIT4:    next_state = ST_INIT5;
         ST_INIT5:    next_state = ST_INIT6;
         ST_INIT6:    next_state = ST_WAIT;
         ST_WAIT:     next_state = decode_req(req_vec);
         ST_WRITE:    next_state = decode_req(req_vec);
         ST_NOP5:     next_state = ST_WRITE;
         ST_PRECH:    next_state = we_i ? ST_WRITE : ST_ACTIVE1;
         ST_ACTIVE1:  next_state = ST_READ;
         ST_ACTIVE2:  next_state = ST_READ;
         ST_READ:     next_state = ST_NOP0;
         ST_NOP0:     next_state = ST_NOP1;
         // A refresh that arrived during a read is only picked up here.
         ST_NOP1:     next_state = autoRef ? ST_ACK_WAIT : ST_WAIT;
         ST_ACK_WAIT: next_state = ack_eff ? ST_PRECH2 : ST_ACK_WAIT;
         ST_PRECH2:   next_state = ST_NOP3;
         // Reopen the interrupted row path if the bank still has one.
         ST_NOP3:     next_state = bankActive ? ST_PRECH : ST_WAIT;
         default:     next_state = ST_WAIT;
      endcase
   end

   // State register plus registered Moore outputs. The outputs are computed
   // from next_state so that they line up with the state they describe, and
   // the async reset puts both back to the init0 values immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_INIT0;
         cmd_q     <= CMD_INHIBIT;
         all_one_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state     <= next_state;
         cmd_q     <= state_cmd(next_state);
         all_one_q <= (next_state == ST_INIT1);
         irq_q     <= IRQ_EN & (next_state == ST_ACK_WAIT);
      end
   end

   // The acknowledged refresh issues precharge-all in the same cycle the
   // CPU raises irqAck, which is the only Mealy path in the controller.
   assign mealy_prech = (state == ST_ACK_WAIT) & ack_eff;

   assign command  = mealy_prech ? CMD_PRECHARGE : cmd_q;
   assign all_one  = all_one_q | mealy_prech;
   assign sdramIRQ = irq_q;
   assign apc      = 1'b0;

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sdram_cmd_sequencer
//
// Directed testbench for sdram_cmd_sequencer. Each scenario task drives a
// short table of request vectors {autoRef, active, bankActive, newRow, we_i}
// one per clock and compares {command, all_one, sdramIRQ} against
// hand-derived expectations, sampled 1 time unit after the rising edge.
// Works in both builds of SDRAM_REFRESH_IRQ_EN.
// ---------------------------------------------------------------------------
module tb_sdram_cmd_sequencer;

   logic       clk;
   logic       rst;
   logic       active;
   logic       bankActive;
   logic       newRow;
   logic       we_i;
   logic       autoRef;
   logic       initCount;
   logic       irqAck;
   logic [3:0] command;
   logic       apc;
   logic       all_one;
   logic       sdramIRQ;

   int n_checks;
   int n_fail;

`ifdef SDRAM_REFRESH_IRQ_EN
   localparam logic EXP_IRQ = 1'b1;
`else
   localparam logic EXP_IRQ = 1'b0;
`endif

   // {command, all_one, sdramIRQ} expectations
   localparam logic [5:0] E_INH  = {4'b1111, 1'b0, 1'b0};
   localparam logic [5:0] E_NOP  = {4'b0111, 1'b0, 1'b0};
   localparam logic [5:0] E_ACT  = {4'b0011, 1'b0, 1'b0};
   localparam logic [5:0] E_RD   = {4'b0101, 1'b0, 1'b0};
   localparam logic [5:0] E_WR   = {4'b0100, 1'b0, 1'b0};
   localparam logic [5:0] E_PRE  = {4'b0010, 1'b0, 1'b0};
   localparam logic [5:0] E_PALL = {4'b0010, 1'b1, 1'b0};
   localparam logic [5:0] E_AR   = {4'b0001, 1'b0, 1'b0};
   localparam logic [5:0] E_LMR  = {4'b0000, 1'b0, 1'b0};
   localparam logic [5:0] E_ACKP = {4'b0010, 1'b1, EXP_IRQ};

   sdram_cmd_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .active     (active),
      .bankActive (bankActive),
      .newRow     (newRow),
      .we_i       (we_i),
      .autoRef    (autoRef),
      .initCount  (initCount),
      .irqAck     (irqAck),
      .command    (command),
      .apc        (apc),
      .all_one    (all_one),
      .sdramIRQ   (sdramIRQ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [4:0] v);
      {autoRef, active, bankActive, newRow, we_i} = v;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      initCount = 1'b0;
      irqAck    = 1'b0;
      applyStimulus(5'b00000);
      #1;
      n_checks++;
      if ({command, all_one, sdramIRQ, apc} !== {E_INH, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL reset_async: got cmd=%b all_one=%b irq=%b apc=%b, expected 1111 0 0 0",
                  command, all_one, sdramIRQ, apc);
      end
      tick;
      tick;
      n_checks++;
      if ({command, all_one, sdramIRQ, apc} !== {E_INH, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL reset_held: got cmd=%b all_one=%b irq=%b apc=%b, expected 1111 0 0 0",
                  command, all_one, sdramIRQ, apc);
      end
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick;
         n_checks++;
         if ({command, all_one, sdramIRQ} !== E_INH) begin
            n_fail++;
            $display("[TB] FAIL init0_wait step %0d: got cmd=%b all_one=%b irq=%b, expected 1111 0 0",
                     i, command, all_one, sdramIRQ);
         end
      end
   endtask

   task automatic test_power_up;
      logic [5:0] exp_v [7];
      exp_v = '{E_PALL, E_AR, E_NOP, E_AR, E_NOP, E_LMR, E_NOP};
      initCount = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick;
         n_checks++;
         if ({command, all_one, sdramIRQ} !== exp_v[i]) begin
            n_fail++;
            $display("[TB] FAIL power_up step %0d: got cmd=%b all_one=%b irq=%b, expected cmd=%b all_one=%b irq=%b",
                     i, command, all_one, sdramIRQ, exp_v[i][5:2], exp_v[i][1], exp_v[i][0]);
         end
      end
   endtask

   task automatic test_read_hit;
      logic [4:0] stim [8];
      logic [5:0] exp_v [8];
      stim  = '{5'b01100, 5'b00000, 5'b00000, 5'b00000, 5'b01100, 5'b00000, 5'b00000, 5'b00000};
      exp_v = '{E_RD, E_NOP, E_NOP, E_NOP, E_RD, E_NOP, E_NOP, E_NOP};
      for (int i = 0; i < 8; i++) begin
         applyStimulus(stim[i]);
         tick;
         n_checks++;
         if ({command, all_one, sdramIRQ} !== exp_v[i]) begin
            n_fail++;
            $display("[TB] FAIL read_hit step %0d: got cmd=%b all_one=%b irq=%b, expected cmd=%b all_one=%b irq=%b",
                     i, command, all_one, sdramIRQ, exp_v[i][5:2], exp_v[i][1], exp_v[i][0]);
         end
      end
   endtask

   task automatic test_read_miss;
      logic [4:0] stim [6];
      logic [5:0] exp_v [6];
      stim  = '{5'b01110, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
      exp_v = '{E_PRE, E_ACT, E_RD, E_NOP, E_NOP, E_NOP};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(stim[i]);
         tick;
         n_checks++;
         if ({command, all_one, sdramIRQ} !== exp_v[i]) begin
            n_fail++;
            $display("[TB] FAIL read_miss step %0d: got cmd=%b all_one=%b irq=%b, expected cmd=%b all_one=%b irq=%b",
                     i, command, all_one, sdramIRQ, exp_v[i][5:2], exp_v[i][1], exp_v[i][0]);
         end
      end
   endtask

   task automatic test_write_hit;
      logic [4:0] stim [3];
      logic [5:0] exp_v [3];
      stim  = '{5'b01101, 5'b00000, 5'b00000};
      exp_v = '{E_NOP, E_WR, E_NOP};
      for (int i = 0; i < 3; i++) begin
         applyStimulus(stim[i]);
         tick;
         n_checks++;
         if ({command, all_one, sdramIRQ} !== exp_v[i]) begin
            n_fail++;
            $display("[TB] FAIL write_hit step %0d: got cmd=%b all_one=%b irq=%b, expected cmd=%b all_one=%b irq=%b",
                     i, command, all_one, sdramIRQ, exp_v[i][5:2], exp_v[i][1], exp_v[i][0]);
         end
      end
   endtask

   // Write miss, then a refresh request arriving while in the write state
   // must beat the still-pending write request.
   task automatic test_write_miss_refresh;
      logic [4:0] stim [6];
      logic [5:0] exp_v [6];
      stim  = '{5'b01111, 5'b01111, 5'b11111, 5'b00000, 5'b00000, 5'b00000};
      exp_v = '{E_PRE, E_WR, E_ACKP, E_AR, E_NOP, E_NOP};
      irqAck = 1'b1;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(stim[i]);
         tick;
         n_checks++;
         if ({command, all_one, sdramIRQ} !== exp_v[i]) begin
            n_fail++;
            $display("[TB] FAIL write_miss_refresh step %0d: got cmd=%b all_one=%b irq=%b, expected cmd=%b all_one=%b irq=%b",
                     i, command, all_one, sdramIRQ, exp_v[i][5:2], exp_v[i][1], exp_v[i][0]);
         end
      end
      irqAck = 1'b0;
   endtask

   task automatic test_back_to_back;
      logic [4:0] stim [7];
      logic [5:0] exp_v [7];
      stim  = '{5'b01011, 5'b01011, 5'b01010, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
      exp_v = '{E_WR, E_WR, E_ACT, E_RD, E_NOP, E_NOP, E_NOP};
      for (int i = 0; i < 7; i++) begin
         applyStimulus(stim[i]);
         tick;
         n_checks++;
         if ({command, all_one, sdramIRQ} !== exp_v[i]) begin
            n_fail++;
            $display("[TB] FAIL back_to_back step %0d: got cmd=%b all_one=%b irq=%b, expected cmd=%b all_one=%b irq=%b",
                     i, command, all_one, sdramIRQ, exp_v[i][5:2], exp_v[i][1], exp_v[i][0]);
         end
      end
   endtask

   // Refresh handshake from waitState.
   task automatic test_refresh;
`ifdef SDRAM_REFRESH_IRQ_EN
      logic [5:0] exp_v [3];
      irqAck = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(i == 0 ? 5'b10000 : 5'b00000);
         tick;
         n_checks++;
         if ({command, all_one, sdramIRQ} !== {4'b0111, 1'b0, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL refresh_ack_wait step %0d: got cmd=%b all_one=%b irq=%b, expected 0111 0 1",
                     i, command, all_one, sdramIRQ);
         end
      end
      irqAck = 1'b1;
      #1;
      n_checks++;
      if ({command, all_one, sdramIRQ} !== {4'b0010, 1'b1, 1'b1}) begin
         n_fail++;
         $display("[TB] FAIL refresh_ack_mealy: got cmd=%b all_one=%b irq=%b, expected 0010 1 1",
                  command, all_one, sdramIRQ);
      end
      exp_v = '{E_AR, E_NOP, E_NOP};
      for (int i = 0; i < 3; i++) begin
         tick;
         irqAck = 1'b0;
         n_checks++;
         if ({command, all_one, sdramIRQ} !== exp_v[i]) begin
            n_fail++;
            $display("[TB] FAIL refresh_tail step %0d: got cmd=%b all_one=%b irq=%b, expected cmd=%b all_one=%b irq=%b",
                     i, command, all_one, sdramIRQ, exp_v[i][5:2], exp_v[i][1], exp_v[i][0]);
         end
      end
`else
      logic [5:0] exp_v [4];
      exp_v  = '{E_PALL, E_AR, E_NOP, E_NOP};
      irqAck = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(i == 0 ? 5'b10000 : 5'b00000);
         tick;
         n_checks++;
         if ({command, all_one, sdramIRQ} !== exp_v[i]) begin
            n_fail++;
            $display("[TB] FAIL refresh_noirq step %0d: got cmd=%b all_one=%b irq=%b, expected cmd=%b all_one=%b irq=%b",
                     i, command, all_one, sdramIRQ, exp_v[i][5:2], exp_v[i][1], exp_v[i][0]);
         end
      end
`endif
   endtask

   // Refresh with the bank still open reopens it via prech/active1/read.
   task automatic test_refresh_bank_open;
      logic [4:0] stim [9];
      logic [5:0] exp_v [9];
      stim  = '{5'b10000, 5'b00100, 5'b00100, 5'b00100, 5'b00000,
                5'b00000, 5'b00000, 5'b00000, 5'b00000};
      exp_v = '{E_ACKP, E_AR, E_NOP, E_PRE, E_ACT, E_RD, E_NOP, E_NOP, E_NOP};
      irqAck = 1'b1;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(stim[i]);
         tick;
         n_checks++;
         if ({command, all_one, sdramIRQ} !== exp_v[i]) begin
            n_fail++;
            $display("[TB] FAIL refresh_bank_open step %0d: got cmd=%b all_one=%b irq=%b, expected cmd=%b all_one=%b irq=%b",
                     i, command, all_one, sdramIRQ, exp_v[i][5:2], exp_v[i][1], exp_v[i][0]);
         end
      end
      irqAck = 1'b0;
   endtask

   // autoRef raised during a read is ignored until nop1.
   task automatic test_refresh_during_read;
      logic [4:0] stim [7];
      logic [5:0] exp_v [7];
      stim  = '{5'b01100, 5'b10000, 5'b10000, 5'b10000, 5'b00000, 5'b00000, 5'b00000};
      exp_v = '{E_RD, E_NOP, E_NOP, E_ACKP, E_AR, E_NOP, E_NOP};
      irqAck = 1'b1;
      for (int i = 0; i < 7; i++) begin
         applyStimulus(stim[i]);
         tick;
         n_checks++;
         if ({command, all_one, sdramIRQ} !== exp_v[i]) begin
            n_fail++;
            $display("[TB] FAIL refresh_during_read step %0d: got cmd=%b all_one=%b irq=%b, expected cmd=%b all_one=%b irq=%b",
                     i, command, all_one, sdramIRQ, exp_v[i][5:2], exp_v[i][1], exp_v[i][0]);
         end
      end
      irqAck = 1'b0;
   endtask

   // Reset between clock edges while in the write state, then re-run init.
   task automatic test_async_reset;
      logic [5:0] exp_v [9];
      exp_v = '{E_INH, E_INH, E_PALL, E_AR, E_NOP, E_AR, E_NOP, E_LMR, E_NOP};
      applyStimulus(5'b01011);
      tick;
      n_checks++;
      if ({command, all_one, sdramIRQ} !== E_WR) begin
         n_fail++;
         $display("[TB] FAIL async_reset_pre: got cmd=%b all_one=%b irq=%b, expected 0100 0 0",
                  command, all_one, sdramIRQ);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({command, all_one, sdramIRQ, apc} !== {E_INH, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL async_reset_now: got cmd=%b all_one=%b irq=%b apc=%b, expected 1111 0 0 0",
                  command, all_one, sdramIRQ, apc);
      end
      #1;
      rst       = 1'b0;
      initCount = 1'b0;
      applyStimulus(5'b00000);
      for (int i = 0; i < 9; i++) begin
         if (i == 2) initCount = 1'b1;
         tick;
         n_checks++;
         if ({command, all_one, sdramIRQ} !== exp_v[i]) begin
            n_fail++;
            $display("[TB] FAIL async_reset_reinit step %0d: got cmd=%b all_one=%b irq=%b, expected cmd=%b all_one=%b irq=%b",
                     i, command, all_one, sdramIRQ, exp_v[i][5:2], exp_v[i][1], exp_v[i][0]);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset;
      test_power_up;
      test_read_hit;
      test_read_miss;
      test_write_hit;
      test_write_miss_refresh;
      test_back_to_back;
      test_refresh;
      test_refresh_bank_open;
      test_refresh_during_read;
      test_async_reset;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sdram_cmd_sequencer.md
# sdram_cmd_sequencer

Main control state machine of the SDRAM memory controller. Runs the SDRAM power-up sequence, then decodes bus-request status into SDRAM commands: activate, read, write, precharge. Runs an interrupt-based refresh handshake with the CPU. Sits between the bus-interface/bank-tracking logic and the SDRAM pin drivers.

## Interface
- No parameters.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- active  in  1  bus request pending.
- bankActive  in  1  target bank has an open row.
- newRow  in  1  request targets a different row than the open one.
- we_i  in  1  request is a write.
- autoRef  in  1  refresh timer expired, refresh required.
- initCount  in  1  power-up delay elapsed.
- irqAck  in  1  CPU acknowledges the refresh interrupt.
- command  out  4  SDRAM command {cs_n, ras_n, cas_n, we_n}.
- apc  out  1  auto-precharge; constant 0.
- all_one  out  1  drive A10 high (precharge all banks).
- sdramIRQ  out  1  refresh interrupt request to CPU.

## Operation
- Command encodings:
  - INHIBIT = 4'b1111
  - NOP = 0111
  - ACTIVE = 0011
  - READ = 0101
  - WRITE = 0100
  - PRECHARGE = 0010
  - AUTO_REFRESH = 0001
  - LOAD_MODE = 0000
- Input vector V = {autoRef, active, bankActive, newRow, we_i}.
- States and commands (Moore unless noted):
  - init0: INHIBIT. Stay while !initCount, else go to init1.
  - init1: PRECHARGE, all_one=1.
  - init2: AUTO_REFRESH.
  - init3: NOP.
  - init4: AUTO_REFRESH.
  - init5: NOP.
  - init6: LOAD_MODE.
  - init1→init6 advance one state per cycle; init6 → waitState.
  - waitState and write use the same request decode below. waitState issues NOP; write issues WRITE.
  - nop5: NOP, → write.
  - prech: PRECHARGE. → write if we_i, else → active1.
  - active1, active2: ACTIVE, → read.
  - read: READ, → nop0.
  - nop0: NOP, → nop1.
  - nop1: NOP. → ackWait if autoRef, else → waitState.
  - ackWait: sdramIRQ=1. If !irqAck: NOP, stay. If irqAck (Mealy): PRECHARGE with all_one=1, → prech2.
  - prech2: AUTO_REFRESH, → nop3.
  - nop3: NOP. → prech if bankActive, else → waitState.
  - Any unused encoding → waitState, command NOP.
- Request decode, first match wins:
  - 01101 → nop5
  - 01100 → read
  - 0111x → prech
  - 010x1 → write
  - 010x0 → active2
  - 00xxx → waitState
  - anything else (autoRef=1) → ackWait
- all_one is 1 only in init1 and in ackWait&irqAck.
- sdramIRQ is 1 only in ackWait.

## Timing
- State register updates on posedge clk; rst forces init0 immediately.
- During reset: command=1111, all_one=0, sdramIRQ=0, apc=0.
- Outputs are combinational from state. In ackWait, command and all_one also depend combinationally on irqAck.
- Inputs are sampled at the clock edge; no internal input registering.
- Read path latency: waitState → read → nop0 → nop1, so READ is 3 cycles before return to waitState.
- Row-miss read path: prech → active1 → read.
- autoRef has priority over every request in waitState/write.
- A refresh request arriving during a read is honoured only in nop1.
- rst mid-operation aborts the current state and restarts the init sequence. initCount must be re-qualified.

## Configuration
- SDRAM_REFRESH_IRQ_EN defined: refresh handshake exactly as above.
- SDRAM_REFRESH_IRQ_EN undefined:
  - sdramIRQ tied 0.
  - irqAck ignored and treated internally as 1, so ackWait lasts one cycle: PRECHARGE-all, then → prech2.

## Test plan
- Power-up: assert rst, then release with initCount=0 for 5 cycles → command=1111 throughout. Set initCount=1 → commands 0010 (all_one=1), 0001, 0111, 0001, 0111, 0000, then NOP in waitState.
- Read hit: V=01100 in waitState → READ next cycle, NOP, NOP, back to waitState.
- Read miss: V=01110 → PRECHARGE, ACTIVE, READ.
- Write miss: V=01111 → PRECHARGE, then WRITE.
- Refresh:
  - autoRef=1 in waitState → ackWait with sdramIRQ=1 and NOP for 4 cycles.
  - Raise irqAck → same cycle command=0010, all_one=1.
  - Then AUTO_REFRESH, NOP, then waitState with sdramIRQ=0.
- Async reset while in write state → state, outputs and command return to init0 values before the next clock edge.
